stft_frame_reader: RTL and testbench
====================================

Name: stft_frame_reader

Overview:
- Read-side controller for the STFT sample buffer RAM (synchronous write, combinational read).
- On a start pulse it walks FRAME_LEN consecutive addresses from a given base, wrapping modulo the buffer depth.
- Streams the words out through a registered valid/ready interface with a last-sample marker.
- Sits between the circular sample buffer and the window/FFT stage. Decides only read addresses; the RAM instance and its writer are elsewhere.

Parameters:
- WORD_WIDTH, 16, sample word width; must match the buffer RAM.
- ADDRESS_WIDTH, 5, buffer address width; buffer depth is 2**ADDRESS_WIDTH.
- FRAME_LEN, 32, samples per frame; legal range 1 .. 2**ADDRESS_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to read a frame; sampled only in IDLE.
- start_addr  in  ADDRESS_WIDTH  base address of the frame; latched with start.
- rd_addr  out  ADDRESS_WIDTH  read address to the buffer RAM.
- rd_data  in  WORD_WIDTH  RAM read data; combinational, valid in the same cycle as rd_addr.
- out_data  out  WORD_WIDTH  streamed sample; registered.
- out_valid  out  1  out_data holds a sample.
- out_last  out  1  qualifies the final sample of the frame; meaningful only with out_valid.
- out_ready  in  1  downstream accepts a sample when out_valid && out_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on acceptance of the last sample.
- start_dropped  out  1  sticky; set when start arrives while busy. Cleared only by rst.

Behaviour:
- Reset (async, immediate): state=IDLE; ptr=0; count=0; out_data=0; out_valid=0; out_last=0; done=0; start_dropped=0.
- rd_addr = ptr at all times (combinational from the register); it is 0 after reset.
- FSM states:
  - IDLE: on start, ptr<=start_addr, count<=0, go to READ.
  - READ: a load occurs in any cycle where (!out_valid || out_ready). On a load:
    - out_data<=rd_data; out_valid<=1; ptr<=ptr+1 (wraps modulo 2**ADDRESS_WIDTH); count<=count+1.
    - out_last<=(count==FRAME_LEN-1).
    - If count==FRAME_LEN-1, go to DRAIN. ptr may advance past the frame; this is harmless.
    - If out_valid && !out_ready, hold everything: no load, and out_data, out_valid, out_last stay stable.
  - DRAIN: wait for out_ready while the final sample is valid. On that handshake: out_valid<=0, out_last<=0, done<=1 for one cycle, go to IDLE.
- Non-final accepts in READ that coincide with a load keep out_valid at 1. This gives full throughput of 1 sample/clk with out_ready held high.
- Latency: start sampled at edge E0. First load occurs at edge E1, so out_valid is high after E1.
- With out_ready constantly high, a frame occupies FRAME_LEN consecutive valid cycles, then done pulses after the last accept.
- start while busy (READ or DRAIN): ignored; start_dropped<=1; the frame in progress is unaffected.
- start in the same cycle that DRAIN completes: ignored and flagged; the FSM is not yet in IDLE.
- FRAME_LEN==1: the first load sets out_last=1 and goes straight to DRAIN.
- Width rules: count is clog2(FRAME_LEN+1) bits. ptr is ADDRESS_WIDTH bits; natural overflow provides the wrap.
- rst asserted mid-frame: all state cleared immediately; the partial frame is abandoned and no done is issued.
- out_data is not required to be 0 when out_valid=0, except after reset.

Test Plan:
- Basic frame: RAM[i]=i+100, start_addr=0, FRAME_LEN=32, out_ready=1 → out_valid high after 1 clk; samples 100..131 on consecutive cycles; out_last only with 131; done pulses once; busy drops to 0 on the following cycle.
- Wrap-around: ADDRESS_WIDTH=5, FRAME_LEN=8, start_addr=28 → rd_addr sequence 28,29,30,31,0,1,2,3; out_data matches RAM at those addresses.
- Backpressure: out_ready toggles 1,0,0,1,… pseudo-randomly → no sample lost or duplicated; out_data and out_last stable while stalled; exactly FRAME_LEN handshakes; done aligned to the last handshake.
- Start while busy: second start issued mid-frame and again in the DRAIN cycle → frame output unchanged; start_dropped=1 and remains 1 until rst.
- Reset mid-frame: assert rst after the 5th accept → out_valid, busy, done, start_dropped and rd_addr all 0 immediately. A new start after release produces a complete, correct frame.
- FRAME_LEN=1: start_addr=7 → single sample RAM[7] with out_last=1; done pulses after its accept.

Source files
------------

// File: rtl/stft_frame_reader_if.sv
// rtl/stft_frame_reader_if.sv - buffer RAM read port and sample output stream
interface stft_frame_reader_if #(
  parameter int WORD_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 5
);
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [WORD_WIDTH-1:0]    rd_data;
  logic [WORD_WIDTH-1:0]    out_data;
  logic                     out_valid;
  logic                     out_last;
  logic                     out_ready;

  modport master (
    output rd_addr, out_data, out_valid, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_addr, out_data, out_valid, out_last,
    output rd_data, out_ready
  );
endinterface

// File: rtl/stft_frame_reader.sv
// rtl/stft_frame_reader.sv - walks one STFT frame out of the circular sample buffer
module stft_frame_reader #(
  parameter int WORD_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 5,
  parameter int FRAME_LEN     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] start_addr,
  stft_frame_reader_if.master      bus,
  output logic                     busy,
  output logic                     done,
  output logic                     start_dropped
);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [ADDRESS_WIDTH-1:0] ptr;
  logic [CW-1:0]            count;
  logic [WORD_WIDTH-1:0]    data_q;
  logic                     valid_q;
  logic                     last_q;
  logic                     load;
  logic                     at_last;
  logic                     drain_ack;
  logic                     accept_start;

  assign bus.rd_addr   = ptr;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A load refills the output register whenever it is empty or being drained this cycle.
  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    drain_ack    = 1'b0;
    accept_start = 1'b0;
    at_last      = (count == LAST_IDX);
    case (state)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_nxt    = READ;
        end
      end
      READ: begin
        if (!valid_q || bus.out_ready) begin
          load = 1'b1;
          if (at_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          drain_ack = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr           <= '0;
      count         <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      done          <= 1'b0;
      start_dropped <= 1'b0;
    end else begin
      done <= drain_ack;
      if (start && state != IDLE) start_dropped <= 1'b1;
      if (accept_start) begin
        ptr   <= start_addr;
        count <= '0;
      end
      // ptr may run one past the frame on the final load; it is reloaded on the next start.
      if (load) begin
        data_q  <= bus.rd_data;
        valid_q <= 1'b1;
        last_q  <= at_last;
        ptr     <= ptr + ADDRESS_WIDTH'(1);
        count   <= count + CW'(1);
      end
      if (drain_ack) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stft_frame_reader.sv
// tb/tb_stft_frame_reader.sv - directed bench for stft_frame_reader at frame lengths 32, 8 and 1
module tb_stft_frame_reader;
  logic clk;
  logic rst;
  logic [2:0] start;
  logic [2:0] rdy;
  logic [4:0] sa_v [3];
  logic [2:0] vld;
  logic [2:0] last_v;
  logic [2:0] busy_v;
  logic [2:0] done_v;
  logic [2:0] drop_v;
  logic [4:0] ra_v [3];
  logic [15:0] data_v [3];
  logic [15:0] ram [32];

  int total;
  int bad;

  stft_frame_reader_if #(.WORD_WIDTH(16), .ADDRESS_WIDTH(5)) if0 ();
  stft_frame_reader_if #(.WORD_WIDTH(16), .ADDRESS_WIDTH(5)) if1 ();
  stft_frame_reader_if #(.WORD_WIDTH(16), .ADDRESS_WIDTH(5)) if2 ();

  stft_frame_reader #(.WORD_WIDTH(16), .ADDRESS_WIDTH(5), .FRAME_LEN(32)) u_fl32 (
    .clk(clk), .rst(rst), .start(start[0]), .start_addr(sa_v[0]), .bus(if0.master),
    .busy(busy_v[0]), .done(done_v[0]), .start_dropped(drop_v[0]));
  stft_frame_reader #(.WORD_WIDTH(16), .ADDRESS_WIDTH(5), .FRAME_LEN(8)) u_fl8 (
    .clk(clk), .rst(rst), .start(start[1]), .start_addr(sa_v[1]), .bus(if1.master),
    .busy(busy_v[1]), .done(done_v[1]), .start_dropped(drop_v[1]));
  stft_frame_reader #(.WORD_WIDTH(16), .ADDRESS_WIDTH(5), .FRAME_LEN(1)) u_fl1 (
    .clk(clk), .rst(rst), .start(start[2]), .start_addr(sa_v[2]), .bus(if2.master),
    .busy(busy_v[2]), .done(done_v[2]), .start_dropped(drop_v[2]));

  assign if0.rd_data = ram[if0.rd_addr];
  assign if1.rd_data = ram[if1.rd_addr];
  assign if2.rd_data = ram[if2.rd_addr];
  assign if0.out_ready = rdy[0];
  assign if1.out_ready = rdy[1];
  assign if2.out_ready = rdy[2];
  assign vld    = {if2.out_valid, if1.out_valid, if0.out_valid};
  assign last_v = {if2.out_last, if1.out_last, if0.out_last};
  assign ra_v[0] = if0.rd_addr;
  assign ra_v[1] = if1.rd_addr;
  assign ra_v[2] = if2.rd_addr;
  assign data_v[0] = if0.out_data;
  assign data_v[1] = if1.out_data;
  assign data_v[2] = if2.out_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          k;
    int          sa;
    int          flen;
    logic [31:0] pat;
    bit          mid;
    logic [15:0] first;
    logic [15:0] last_d;
    bit          drop;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Entered and left #1 after a rising edge.
  task automatic run_frame(input vec_t v);
    int acc;
    int loads;
    int cyc;
    bit stalled;
    logic [15:0] hold_d;
    logic hold_l;
    logic [15:0] exp_d;
    int k;
    k = v.k;
    acc = 0; loads = 0; cyc = 0; stalled = 0;
    hold_d = '0; hold_l = 1'b0;
    sa_v[k] = 5'(v.sa);
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    check("busy_after_start", busy_v[k], 1);
    check("valid_latency", vld[k], 0);
    while (acc < v.flen && cyc < 400) begin
      rdy[k] = v.pat[cyc % 32];
      check("no_early_done", done_v[k], 0);
      if (loads < v.flen && (!vld[k] || rdy[k])) begin
        check("rd_addr", ra_v[k], (v.sa + loads) % 32);
        loads++;
      end
      if (stalled) begin
        check("stall_valid", vld[k], 1);
        check("stall_data", data_v[k], hold_d);
        check("stall_last", last_v[k], hold_l);
      end
      if (vld[k]) begin
        if (rdy[k]) begin
          exp_d = 16'(((v.sa + acc) % 32) + 100);
          check("sample_data", data_v[k], exp_d);
          check("sample_last", last_v[k], (acc == v.flen - 1) ? 1 : 0);
          if (acc == 0) check("first_data", data_v[k], v.first);
          if (acc == v.flen - 1) check("last_data", data_v[k], v.last_d);
          if (v.mid && (acc == 3 || acc == v.flen - 1)) start[k] = 1'b1;
          acc++;
          stalled = 0;
        end else begin
          stalled = 1;
          hold_d = data_v[k];
          hold_l = last_v[k];
        end
      end
      @(posedge clk); #1;
      start[k] = 1'b0;
      cyc++;
    end
    check("handshake_count", acc, v.flen);
    check("done_pulse", done_v[k], 1);
    check("valid_after_frame", vld[k], 0);
    check("busy_after_frame", busy_v[k], 0);
    check("start_dropped", drop_v[k], v.drop);
    rdy[k] = 1'b1;
    @(posedge clk); #1;
    check("done_one_cycle", done_v[k], 0);
    check("stay_idle", busy_v[k], 0);
  endtask

  vec_t vecs [8];
  vec_t rv;

  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    int cnt;
    int cyc;
    total = 0; bad = 0;
    for (int i = 0; i < 32; i++) ram[i] = 16'(i + 100);
    vecs[0] = '{0, 0,  32, 32'hFFFF_FFFF, 0, 16'd100, 16'd131, 0};
    vecs[1] = '{1, 28, 8,  32'hFFFF_FFFF, 0, 16'd128, 16'd103, 0};
    vecs[2] = '{1, 5,  8,  32'h3A5C_96E1, 0, 16'd105, 16'd112, 0};
    vecs[3] = '{0, 17, 32, 32'h9B3C_5A71, 0, 16'd117, 16'd116, 0};
    vecs[4] = '{2, 7,  1,  32'hFFFF_FFFF, 0, 16'd107, 16'd107, 0};
    vecs[5] = '{2, 31, 1,  32'hFFFF_FF00, 0, 16'd131, 16'd131, 0};
    vecs[6] = '{1, 3,  8,  32'hFFFF_FFFF, 1, 16'd103, 16'd110, 1};
    vecs[7] = '{0, 20, 32, 32'h5555_AAAA, 0, 16'd120, 16'd119, 0};

    rst = 1'b1;
    start = '0;
    rdy = '1;
    for (int i = 0; i < 3; i++) sa_v[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_valid", vld[i], 0);
      check("reset_last", last_v[i], 0);
      check("reset_busy", busy_v[i], 0);
      check("reset_done", done_v[i], 0);
      check("reset_dropped", drop_v[i], 0);
      check("reset_rd_addr", ra_v[i], 0);
      check("reset_data", data_v[i], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    // Abandon a frame after its fifth accept.
    sa_v[0] = 5'd10;
    start[0] = 1'b1;
    rdy[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    cnt = 0; cyc = 0;
    while (cnt < 5 && cyc < 100) begin
      if (vld[0]) cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_mid_accepts", cnt, 5);
    check("rst_mid_busy_before", busy_v[0], 1);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", vld[0], 0);
    check("rst_mid_last", last_v[0], 0);
    check("rst_mid_busy", busy_v[0], 0);
    check("rst_mid_done", done_v[0], 0);
    check("rst_mid_rd_addr", ra_v[0], 0);
    check("rst_mid_dropped_fl8", drop_v[1], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_done", done_v[0], 0);
    rv = '{0, 10, 32, 32'hFFFF_FFFF, 0, 16'd110, 16'd109, 0};
    run_frame(rv);
    rv = '{1, 30, 8, 32'hFFFF_FFFF, 0, 16'd130, 16'd105, 0};
    run_frame(rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
